// File: rtl/ssb_timing_pkg.sv
// ssb_timing_pkg: shared SSB timing states, symbol-index constants and length helpers
package ssb_timing_pkg;
    typedef enum logic [1:0] {SEARCH, SSB_SYMS, TRACK_WAIT, TRACK_WIN} state_t;
    localparam int PBCH0 = 1;
    localparam int SSS = 2;
    localparam int PBCH1 = 3;
    function automatic int fft_len(input int nfft);
        return 1 << nfft;
    endfunction
    function automatic int sym_len(input int nfft, input int cp);
        return fft_len(nfft) + cp;
    endfunction
    function automatic int sym_offset(input int idx, input int sl);
        return (idx - 1) * sl;
    endfunction
endpackage

// File: rtl/ssb_symbol_seq.sv
// ssb_symbol_seq: counts the three SSB symbols after go_i (clk_i, reset_ni, go_i, en_i, valid_i in; done_o and registered strobes out)
module ssb_symbol_seq import ssb_timing_pkg::*; #(
    parameter int SYM_LEN = 274
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic go_i,
    input  logic en_i,
    input  logic valid_i,
    output logic done_o,
    output logic symbol_start_o,
    output logic SSB_start_o,
    output logic PBCH_start_o,
    output logic SSS_start_o
);
    localparam int CW = $clog2(3 * SYM_LEN);
    localparam logic [CW-1:0] OFF_P0 = CW'(sym_offset(PBCH0, SYM_LEN));
    localparam logic [CW-1:0] OFF_SSS = CW'(sym_offset(SSS, SYM_LEN));
    localparam logic [CW-1:0] OFF_P1 = CW'(sym_offset(PBCH1, SYM_LEN));
    localparam logic [CW-1:0] OFF_LAST = CW'(3 * SYM_LEN - 1);
    logic [CW-1:0] sym_cnt;
    logic step, at_p0, at_sss, at_p1;
    always_comb begin
        step = en_i && valid_i;
        at_p0 = step && sym_cnt == OFF_P0;
        at_sss = step && sym_cnt == OFF_SSS;
        at_p1 = step && sym_cnt == OFF_P1;
        done_o = step && sym_cnt == OFF_LAST;
    end
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            sym_cnt <= '0;
            symbol_start_o <= 1'b0;
            SSB_start_o <= 1'b0;
            PBCH_start_o <= 1'b0;
            SSS_start_o <= 1'b0;
        end else begin
            sym_cnt <= (go_i || done_o) ? '0 : step ? sym_cnt + 1'b1 : sym_cnt;
            symbol_start_o <= at_p0 || at_sss || at_p1;
            SSB_start_o <= at_p0;
            PBCH_start_o <= at_p0 || at_p1;
            SSS_start_o <= at_sss;
        end
    end
endmodule

// File: rtl/ssb_timing_ctrl.sv
// ssb_timing_ctrl: PSS-peak driven SSB acquisition/tracking FSM (clk_i, reset_ni, s_axis_in_tvalid, peak_i, N_id_2_i in; mode, N_id_2, strobes, sync_lost, miss_count out)
module ssb_timing_ctrl import ssb_timing_pkg::*; #(
    parameter int NFFT = 8,
    parameter int CP_LEN = 18,
    parameter int SSB_PERIOD = 76800,
    parameter int WINDOW = 8,
    parameter int MAX_MISSES = 3
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic s_axis_in_tvalid,
    input  logic peak_i,
    input  logic [1:0] N_id_2_i,
    output logic detector_mode_o,
    output logic [1:0] requested_N_id_2_o,
    output logic symbol_start_o,
    output logic SSB_start_o,
    output logic PBCH_start_o,
    output logic SSS_start_o,
    output logic sync_lost_o,
    output logic [$clog2(MAX_MISSES+1)-1:0] miss_count_o
);
    localparam int PW = $clog2(SSB_PERIOD + WINDOW + 1);
    localparam int MW = $clog2(MAX_MISSES + 1);
    localparam logic [PW-1:0] OPEN_LAST = PW'(SSB_PERIOD - WINDOW - 1);
    localparam logic [PW-1:0] WIN_LAST = PW'(SSB_PERIOD + WINDOW);
    localparam logic [PW-1:0] REGRID = PW'(WINDOW);
    localparam logic [MW-1:0] MISS_LAST = MW'(MAX_MISSES - 1);
    state_t state_q, state_d;
    logic [PW-1:0] period_q, period_d, period_inc;
    logic [MW-1:0] miss_d;
    logic [1:0] nid_d;
    logic mode_d, lost_d, go, seq_done;
    ssb_symbol_seq #(.SYM_LEN(sym_len(NFFT, CP_LEN))) u_seq (
        .clk_i(clk_i),
        .reset_ni(reset_ni),
        .go_i(go),
        .en_i(state_q == SSB_SYMS),
        .valid_i(s_axis_in_tvalid),
        .done_o(seq_done),
        .symbol_start_o(symbol_start_o),
        .SSB_start_o(SSB_start_o),
        .PBCH_start_o(PBCH_start_o),
        .SSS_start_o(SSS_start_o)
    );
    always_comb begin
        state_d = state_q;
        period_inc = period_q + PW'(s_axis_in_tvalid);
        period_d = period_q;
        miss_d = miss_count_o;
        nid_d = requested_N_id_2_o;
        mode_d = detector_mode_o;
        lost_d = 1'b0;
        go = 1'b0;
        case (state_q)
            SEARCH: if (peak_i) begin
                state_d = SSB_SYMS;
                nid_d = N_id_2_i;
                miss_d = '0;
                period_d = '0;
                go = 1'b1;
            end
            SSB_SYMS: begin
                period_d = period_inc;
                if (seq_done) begin
                    state_d = TRACK_WAIT;
                    mode_d = 1'b1;
                end
            end
            TRACK_WAIT: begin
                period_d = period_inc;
                if (s_axis_in_tvalid && period_q == OPEN_LAST) state_d = TRACK_WIN;
            end
            TRACK_WIN: if (peak_i) begin
                state_d = SSB_SYMS;
                period_d = '0;
                miss_d = '0;
                go = 1'b1;
            end else if (s_axis_in_tvalid) begin
                if (period_q != WIN_LAST) period_d = period_inc;
                else if (miss_count_o == MISS_LAST) begin
                    state_d = SEARCH;
                    period_d = '0;
                    miss_d = '0;
                    mode_d = 1'b0;
                    lost_d = 1'b1;
                end else begin
                    state_d = TRACK_WAIT;
                    period_d = REGRID;
                    miss_d = miss_count_o + 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= SEARCH;
            period_q <= '0;
            miss_count_o <= '0;
            requested_N_id_2_o <= '0;
            detector_mode_o <= 1'b0;
            sync_lost_o <= 1'b0;
        end else begin
            state_q <= state_d;
            period_q <= period_d;
            miss_count_o <= miss_d;
            requested_N_id_2_o <= nid_d;
            detector_mode_o <= mode_d;
            sync_lost_o <= lost_d;
        end
    end
endmodule

// File: tb/tb_ssb_timing_ctrl.sv
// tb_ssb_timing_ctrl: directed table and sequence checks of ssb_timing_ctrl with a shortened SSB period
module tb_ssb_timing_ctrl;
    localparam int P = 2000;
    localparam int W = 8;
    localparam int M = 3;
    logic clk_i = 1'b0;
    logic reset_ni = 1'b0;
    logic s_axis_in_tvalid = 1'b1;
    logic peak_i = 1'b0;
    logic [1:0] N_id_2_i = 2'd0;
    logic detector_mode_o, symbol_start_o, SSB_start_o, PBCH_start_o, SSS_start_o, sync_lost_o;
    logic [1:0] requested_N_id_2_o;
    logic [1:0] miss_count_o;
    int t, checks, errors, ssb_n, sym_n, snap_ssb, snap_sym;
    bit duty;
    typedef struct {
        logic peak;
        logic [1:0] nid;
        int ticks;
        logic [9:0] exp;
    } vec_t;
    vec_t vt [9];
    ssb_timing_ctrl #(.NFFT(8), .CP_LEN(18), .SSB_PERIOD(P), .WINDOW(W), .MAX_MISSES(M)) dut (
        .clk_i(clk_i),
        .reset_ni(reset_ni),
        .s_axis_in_tvalid(s_axis_in_tvalid),
        .peak_i(peak_i),
        .N_id_2_i(N_id_2_i),
        .detector_mode_o(detector_mode_o),
        .requested_N_id_2_o(requested_N_id_2_o),
        .symbol_start_o(symbol_start_o),
        .SSB_start_o(SSB_start_o),
        .PBCH_start_o(PBCH_start_o),
        .SSS_start_o(SSS_start_o),
        .sync_lost_o(sync_lost_o),
        .miss_count_o(miss_count_o)
    );
    always #5 clk_i = ~clk_i;
    function automatic logic [9:0] e(input logic m, input logic [1:0] n, input logic sy, input logic ss,
                                     input logic pb, input logic sc, input logic lo, input logic [1:0] mi);
        return {m, n, sy, ss, pb, sc, lo, mi};
    endfunction
    function automatic logic [9:0] outs();
        return {detector_mode_o, requested_N_id_2_o, symbol_start_o, SSB_start_o, PBCH_start_o,
                SSS_start_o, sync_lost_o, miss_count_o};
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", nm, act, exp, t);
        end
    endtask
    task automatic tick();
        @(posedge clk_i);
        #1;
        t++;
        ssb_n += int'(SSB_start_o);
        sym_n += int'(symbol_start_o);
        if (duty) s_axis_in_tvalid = ~s_axis_in_tvalid;
    endtask
    task automatic adv(input int m);
        while (t < m) tick();
    endtask
    task automatic peak_at(input int m, input logic [1:0] nid);
        adv(m - 1);
        peak_i = 1'b1;
        N_id_2_i = nid;
        tick();
        peak_i = 1'b0;
    endtask
    task automatic do_reset();
        reset_ni = 1'b0;
        tick();
        tick();
        reset_ni = 1'b1;
    endtask
    initial begin
        vt[0] = '{1'b1, 2'd2, 1, e(0, 2, 0, 0, 0, 0, 0, 0)};
        vt[1] = '{1'b0, 2'd0, 1, e(0, 2, 1, 1, 1, 0, 0, 0)};
        vt[2] = '{1'b0, 2'd0, 1, e(0, 2, 0, 0, 0, 0, 0, 0)};
        vt[3] = '{1'b1, 2'd1, 100, e(0, 2, 0, 0, 0, 0, 0, 0)};
        vt[4] = '{1'b0, 2'd0, 172, e(0, 2, 0, 0, 0, 0, 0, 0)};
        vt[5] = '{1'b0, 2'd0, 1, e(0, 2, 1, 0, 0, 1, 0, 0)};
        vt[6] = '{1'b0, 2'd0, 274, e(0, 2, 1, 0, 1, 0, 0, 0)};
        vt[7] = '{1'b0, 2'd0, 272, e(0, 2, 0, 0, 0, 0, 0, 0)};
        vt[8] = '{1'b0, 2'd0, 1, e(1, 2, 0, 0, 0, 0, 0, 0)};
        do_reset();
        chk("reset", 32'(outs()), 32'd0);
        t = -1;
        for (int i = 0; i < 9; i++) begin
            peak_i = vt[i].peak;
            N_id_2_i = vt[i].nid;
            repeat (vt[i].ticks) tick();
            chk($sformatf("acq%0d", i), 32'(outs()), 32'(vt[i].exp));
        end
        peak_i = 1'b0;
        peak_at(P, 2'd2);
        t = 0;
        chk("hit_nom", 32'(outs()), 32'(e(1, 2, 0, 0, 0, 0, 0, 0)));
        tick();
        chk("hit_nom_ssb", 32'(outs()), 32'(e(1, 2, 1, 1, 1, 0, 0, 0)));
        peak_at(P + 5, 2'd3);
        t = 0;
        tick();
        chk("hit_p5_ssb", 32'(outs()), 32'(e(1, 2, 1, 1, 1, 0, 0, 0)));
        adv(275);
        chk("hit_p5_sss", 32'(outs()), 32'(e(1, 2, 1, 0, 0, 1, 0, 0)));
        adv(822);
        snap_ssb = ssb_n;
        snap_sym = sym_n;
        peak_at(P - 9, 2'd1);
        adv(P + W);
        chk("win_last_open", 32'(outs()), 32'(e(1, 2, 0, 0, 0, 0, 0, 0)));
        adv(P + W + 1);
        chk("close1", 32'(outs()), 32'(e(1, 2, 0, 0, 0, 0, 0, 1)));
        peak_at(P + 10, 2'd1);
        adv(P + 14);
        chk("miss_ssb_cnt", 32'(ssb_n - snap_ssb), 32'd0);
        chk("miss_sym_cnt", 32'(sym_n - snap_sym), 32'd0);
        peak_at(2 * P + 10, 2'd1);
        t = 0;
        chk("last_hit", 32'(outs()), 32'(e(1, 2, 0, 0, 0, 0, 0, 0)));
        tick();
        chk("last_hit_ssb", 32'(outs()), 32'(e(1, 2, 1, 1, 1, 0, 0, 0)));
        adv(P + W);
        chk("loss_m0", 32'(miss_count_o), 32'd0);
        adv(P + W + 1);
        chk("loss_m1", 32'(outs()), 32'(e(1, 2, 0, 0, 0, 0, 0, 1)));
        adv(2 * P + W + 2);
        chk("loss_m2", 32'(outs()), 32'(e(1, 2, 0, 0, 0, 0, 0, 2)));
        adv(3 * P + W + 2);
        chk("loss_pre", 32'(outs()), 32'(e(1, 2, 0, 0, 0, 0, 0, 2)));
        adv(3 * P + W + 3);
        chk("sync_lost", 32'(outs()), 32'(e(0, 2, 0, 0, 0, 0, 1, 0)));
        tick();
        chk("sync_lost_1cyc", 32'(outs()), 32'(e(0, 2, 0, 0, 0, 0, 0, 0)));
        peak_at(t + 2, 2'd1);
        chk("reacq", 32'(outs()), 32'(e(0, 1, 0, 0, 0, 0, 0, 0)));
        tick();
        chk("reacq_ssb", 32'(outs()), 32'(e(0, 1, 1, 1, 1, 0, 0, 0)));
        duty = 1'b0;
        s_axis_in_tvalid = 1'b1;
        do_reset();
        s_axis_in_tvalid = 1'b0;
        duty = 1'b1;
        peak_i = 1'b1;
        N_id_2_i = 2'd2;
        tick();
        peak_i = 1'b0;
        t = 0;
        chk("duty_acq_novalid", 32'(outs()), 32'(e(0, 2, 0, 0, 0, 0, 0, 0)));
        tick();
        chk("duty_ssb", 32'(outs()), 32'(e(0, 2, 1, 1, 1, 0, 0, 0)));
        adv(548);
        chk("duty_pre_sss", 32'(outs()), 32'(e(0, 2, 0, 0, 0, 0, 0, 0)));
        adv(549);
        chk("duty_sss", 32'(outs()), 32'(e(0, 2, 1, 0, 0, 1, 0, 0)));
        adv(1097);
        chk("duty_pbch1", 32'(outs()), 32'(e(0, 2, 1, 0, 1, 0, 0, 0)));
        adv(1642);
        chk("duty_mode0", 32'(detector_mode_o), 32'd0);
        adv(1643);
        chk("duty_mode1", 32'(detector_mode_o), 32'd1);
        adv(2 * (P + W));
        chk("duty_win_open", 32'(outs()), 32'(e(1, 2, 0, 0, 0, 0, 0, 0)));
        adv(2 * (P + W) + 1);
        chk("duty_close", 32'(outs()), 32'(e(1, 2, 0, 0, 0, 0, 0, 1)));
        duty = 1'b0;
        s_axis_in_tvalid = 1'b1;
        do_reset();
        peak_i = 1'b1;
        N_id_2_i = 2'd3;
        tick();
        peak_i = 1'b0;
        t = 0;
        adv(300);
        reset_ni = 1'b0;
        tick();
        reset_ni = 1'b1;
        chk("rst_mid", 32'(outs()), 32'd0);
        snap_sym = sym_n;
        adv(1400);
        chk("rst_no_strobes", 32'(sym_n - snap_sym), 32'd0);
        chk("rst_idle", 32'(outs()), 32'd0);
        peak_i = 1'b1;
        N_id_2_i = 2'd1;
        tick();
        peak_i = 1'b0;
        tick();
        chk("rst_reacq", 32'(outs()), 32'(e(0, 1, 1, 1, 1, 0, 0, 0)));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
